consumer: RTL and testbench

Read-side endpoint of the `async_fifo` path, and the counterpart to `producer` on the write side. It runs entirely in the read clock domain. It issues read enables to the FIFO core only when the FIFO is not empty and buffer space is guaranteed. It captures the FIFO's registered read data into a 2-entry skid buffer and presents words downstream through a valid/request handshake. Downstream back-pressure therefore never drops or duplicates a word, and full throughput of one word per cycle is sustained.

---
 rtl/consumer_if.sv | 20 ++
 rtl/consumer.sv | 48 ++++
 tb/tb_consumer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/consumer_if.sv
// async_fifo: read-side signal bundle shared by the FIFO core and the consumer.
interface async_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input logic r_clk,
  input logic rrst
);
  logic                  rd_req;
  logic                  empty;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  r_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic [CNT_WIDTH-1:0]  rd_count;
  modport consumer_if (
    input  r_clk, rrst, rd_req, empty, fifo_dout,
    output r_en, data_out, data_valid, rd_count
  );
endinterface

// File: rtl/consumer.sv
// consumer: read-domain FIFO endpoint with a 2-entry skid buffer and delivered-word counter.
module consumer #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  async_fifo.consumer_if pif
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} occ_t;
  occ_t                  occ_q, occ_d;
  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  data_valid, pop, r_en;
  logic [1:0]            after_pop, occ_sum;
  // A read is issued only if the word it brings back is sure to find a slot.
  always_comb begin
    data_valid = occ_q != EMPTY;
    pop        = data_valid & pif.rd_req;
    after_pop  = 2'(occ_q) - {1'b0, pop};
    occ_sum    = after_pop + {1'b0, inflight_q};
    r_en       = pif.rrst & !pif.empty & (occ_sum < 2'd2);
    occ_d      = occ_t'(occ_sum);
    inflight_d = r_en;
    cnt_d      = cnt_q + CNT_WIDTH'(pop);
    buf0_d     = pop ? buf1_q : buf0_q;
    buf1_d     = buf1_q;
    if (inflight_q && after_pop == 2'd0) buf0_d = pif.fifo_dout;
    if (inflight_q && after_pop == 2'd1) buf1_d = pif.fifo_dout;
  end
  always_ff @(posedge pif.r_clk or negedge pif.rrst)
    if (!pif.rrst) begin
      occ_q      <= EMPTY;
      inflight_q <= 1'b0;
      buf0_q     <= '0;
      buf1_q     <= '0;
      cnt_q      <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      cnt_q      <= cnt_d;
    end
  assign pif.r_en       = r_en;
  assign pif.data_valid = data_valid;
  assign pif.rd_count   = cnt_q;
  assign pif.data_out   = data_valid ? buf0_q : {DATA_WIDTH{1'bz}};
endmodule

// File: tb/tb_consumer.sv
// tb_consumer: directed checks of the consumer against a small behavioural FIFO core.
module tb_consumer;
  logic clk = 1'b0;
  logic rrst = 1'b1;
  always #5 clk = ~clk;

  async_fifo #(.DATA_WIDTH(32), .CNT_WIDTH(16)) ifc (.r_clk(clk), .rrst(rrst));
  async_fifo #(.DATA_WIDTH(32), .CNT_WIDTH(4))  ifw (.r_clk(clk), .rrst(rrst));
  consumer #(.DATA_WIDTH(32), .CNT_WIDTH(16)) u_dut  (.pif(ifc));
  consumer #(.DATA_WIDTH(32), .CNT_WIDTH(4))  u_wrap (.pif(ifw));

  logic [31:0] mem1 [32];
  logic [31:0] mem2 [32];
  int wp1 = 0, rp1 = 0, wp2 = 0, rp2 = 0;
  assign ifc.empty = (rp1 == wp1);
  assign ifw.empty = (rp2 == wp2);
  always @(posedge clk or negedge rrst)
    if (!rrst) begin
      rp1 <= 0;
      ifc.fifo_dout <= '0;
    end else if (ifc.r_en) begin
      ifc.fifo_dout <= mem1[rp1];
      rp1 <= rp1 + 1;
    end
  always @(posedge clk or negedge rrst)
    if (!rrst) begin
      rp2 <= 0;
      ifw.fifo_dout <= '0;
    end else if (ifw.r_en) begin
      ifw.fifo_dout <= mem2[rp2];
      rp2 <= rp2 + 1;
    end

  always @(negedge clk)
    if (rrst) assert (2'(u_dut.occ_q) <= 2'd2 && 2'(u_wrap.occ_q) <= 2'd2);

  int checks = 0, errors = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push1(input logic [31:0] w);
    mem1[wp1] = w;
    wp1++;
  endtask
  task automatic do_reset();
    rrst = 1'b0;
    wp1 = 0;
    wp2 = 0;
    ifc.rd_req = 1'b0;
    ifw.rd_req = 1'b0;
    step();
    rrst = 1'b1;
  endtask

  logic [31:0] got [$];
  int first, last, ren_cycles;

  initial begin
    ifc.rd_req = 1'b0;
    ifw.rd_req = 1'b0;
    step();
    rrst = 1'b0;
    #1;
    check("rst_ren", ifc.r_en, 0);
    check("rst_dv", ifc.data_valid, 0);
    check("rst_cnt", ifc.rd_count, 0);
    step();
    rrst = 1'b1;

    ifc.rd_req = 1'b1;
    push1(32'hA5A5_0001);
    #1;
    check("sw_ren_pulse", ifc.r_en, 1);
    step(); #1;
    check("sw_ren_off", ifc.r_en, 0);
    check("sw_dv_wait", ifc.data_valid, 0);
    step(); #1;
    check("sw_dv", ifc.data_valid, 1);
    check("sw_dout", ifc.data_out, 32'hA5A5_0001);
    step(); #1;
    check("sw_dv_off", ifc.data_valid, 0);
    check("sw_cnt", ifc.rd_count, 1);

    do_reset();
    ifc.rd_req = 1'b1;
    for (int i = 1; i <= 8; i++) push1(i);
    got.delete();
    first = -1; last = -1; ren_cycles = 0;
    for (int c = 0; c < 14; c++) begin
      #1;
      if (ifc.r_en) ren_cycles++;
      if (ifc.data_valid) begin
        got.push_back(ifc.data_out);
        if (first < 0) first = c;
        last = c;
      end
      step();
    end
    check("st_words", got.size(), 8);
    for (int i = 0; i < got.size() && i < 8; i++) check("st_data", got[i], i + 1);
    check("st_contig", last - first, 7);
    check("st_first", first, 2);
    check("st_ren", ren_cycles, 8);
    check("st_cnt", ifc.rd_count, 8);

    do_reset();
    for (int i = 1; i <= 6; i++) push1(i);
    got.delete();
    for (int c = 0; c < 18; c++) begin
      ifc.rd_req = !(c >= 4 && c <= 8);
      #1;
      if (ifc.data_valid && ifc.rd_req) got.push_back(ifc.data_out);
      if (c >= 4 && c <= 8) begin
        check("bp_ren", ifc.r_en, 0);
        check("bp_hold", ifc.data_out, 3);
        check("bp_dv", ifc.data_valid, 1);
      end
      if (c >= 5 && c <= 8) check("bp_tail", u_dut.buf1_q, 4);
      step();
    end
    check("bp_words", got.size(), 6);
    for (int i = 0; i < got.size() && i < 6; i++) check("bp_data", got[i], i + 1);
    check("bp_cnt", ifc.rd_count, 6);

    do_reset();
    ifc.rd_req = 1'b1;
    push1(32'h0000_00AA);
    push1(32'h0000_00BB);
    step(); #1;
    check("ee_ren2", ifc.r_en, 1);
    step(); #1;
    check("ee_empty", ifc.empty, 1);
    check("ee_ren_off", ifc.r_en, 0);
    check("ee_w1", ifc.data_out, 32'hAA);
    step(); #1;
    check("ee_w2", ifc.data_out, 32'hBB);
    check("ee_ren_off2", ifc.r_en, 0);
    step(); #1;
    check("ee_dv_off", ifc.data_valid, 0);
    check("ee_cnt", ifc.rd_count, 2);

    do_reset();
    for (int i = 1; i <= 4; i++) push1(i);
    for (int c = 0; c < 4; c++) begin
      ifc.rd_req = (c <= 2);
      step();
    end
    #1;
    check("mr_full_dv", ifc.data_valid, 1);
    check("mr_full_dout", ifc.data_out, 2);
    check("mr_full_cnt", ifc.rd_count, 1);
    rrst = 1'b0;
    wp1 = 0;
    #1;
    check("mr_dv", ifc.data_valid, 0);
    check("mr_ren", ifc.r_en, 0);
    check("mr_cnt", ifc.rd_count, 0);
    step();
    rrst = 1'b1;
    #1;
    check("mr_dv_after", ifc.data_valid, 0);

    do_reset();
    for (int i = 0; i < 17; i++) mem2[i] = 32'h100 + i;
    wp2 = 17;
    ifw.rd_req = 1'b1;
    for (int c = 0; c < 30; c++) step();
    #1;
    check("wrap_cnt", ifw.rd_count, 1);
    check("wrap_dv", ifw.data_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
